mem_access_unit: RTL and testbench

//  MEM-stage responder for the load/store control decoded in ID: takes the registered
//  mem_we/mem_read/mem_byte/mem_signextend/mem_sc request plus ALU address, runs a
//  req/ack transaction on the data-memory port, aligns load data, owns the LL/SC

---
 rtl/mem_access_unit_pkg.sv | 48 ++++
 rtl/mem_access_unit_load_align.sv | 23 ++
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage access unit: FSM states,
// byte-lane constants and the data-memory command payload.
package mem_access_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned WADDR_W = 30;
    localparam int unsigned CNT_W   = 8;

    localparam logic [BE_W-1:0] BE_WORD  = 4'hF;
    localparam logic [BE_W-1:0] BE_BYTE0 = 4'h1;

    typedef enum logic [1:0] {
        MAU_IDLE   = 2'd0,
        MAU_ACCESS = 2'd1,
        MAU_DONE   = 2'd2
    } mau_state_e;

    typedef struct packed {
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_cmd_t;

    // Per-access context kept while the bus transaction is outstanding.
    typedef struct packed {
        logic       ll;
        logic       sc;
        logic       byte_op;
        logic       sext;
        logic [1:0] ofs;
    } mau_ctx_t;

    // Word-aligned address, lane enables and lane-replicated store data.
    function automatic dmem_cmd_t build_cmd(input logic            we,
                                            input logic            byte_op,
                                            input logic [XLEN-1:0] addr,
                                            input logic [XLEN-1:0] wdata);
        dmem_cmd_t cmd;
        cmd.we    = we;
        cmd.addr  = {addr[XLEN-1:2], 2'b00};
        cmd.be    = byte_op ? BE_W'(BE_BYTE0 << addr[1:0]) : BE_WORD;
        cmd.wdata = byte_op ? {4{wdata[7:0]}} : wdata;
        return cmd;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: selects the addressed byte lane and extends it, or
// passes the whole word through for word loads.
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic [1:0]      byte_sel,
    input  logic            mem_byte,
    input  logic            mem_signextend,
    output logic [XLEN-1:0] result_c
);

    logic [7:0] lane;

    always_comb begin
        lane     = 8'(dmem_rdata >> {byte_sel, 3'b000});
        result_c = dmem_rdata;
        if (mem_byte) begin
            result_c = {{24{mem_signextend & lane[7]}}, lane};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: runs the req/ack data-memory transaction,
// aligns load data, owns the LL/SC reservation and stalls until completion.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic            mem_we,
    input  logic            mem_read,
    input  logic            mem_byte,
    input  logic            mem_signextend,
    input  logic            mem_sc,
    input  logic            mem_ll,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            ll_clear,
    output logic            stall,
    output logic [XLEN-1:0] rdata,
    output logic            align_err,
    output logic            bus_err,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [BE_W-1:0] dmem_be,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata
);

    mau_state_e         state_q, state_d;
    dmem_cmd_t          cmd_q, cmd_d;
    mau_ctx_t           ctx_q, ctx_d;
    logic               req_q, req_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               align_err_q, align_err_d;
    logic               bus_err_q, bus_err_d;
    logic               llbit_q, llbit_d;
    logic [WADDR_W-1:0] ll_addr_q, ll_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [XLEN-1:0]    aligned_c;
    dmem_cmd_t          issue_cmd_c;
    logic               misaligned_c;
    logic               sc_ok_c;
    logic               is_mem_op_c;

    mem_access_unit_load_align u_load_align (
        .dmem_rdata    (dmem_rdata),
        .byte_sel      (ctx_q.ofs),
        .mem_byte      (ctx_q.byte_op),
        .mem_signextend(ctx_q.sext),
        .result_c      (aligned_c)
    );

    assign stall      = req_valid & (state_q != MAU_DONE);
    assign rdata      = rdata_q;
    assign align_err  = align_err_q;
    assign bus_err    = bus_err_q;
    assign dmem_req   = req_q;
    assign dmem_we    = cmd_q.we;
    assign dmem_be    = cmd_q.be;
    assign dmem_addr  = cmd_q.addr;
    assign dmem_wdata = cmd_q.wdata;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MAU_IDLE;
            cmd_q       <= '0;
            ctx_q       <= '0;
            req_q       <= 1'b0;
            rdata_q     <= '0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
            llbit_q     <= 1'b0;
            ll_addr_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            ctx_q       <= ctx_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
            llbit_q     <= llbit_d;
            ll_addr_q   <= ll_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        ctx_d       = ctx_q;
        req_d       = req_q;
        rdata_d     = rdata_q;
        align_err_d = 1'b0;
        bus_err_d   = 1'b0;
        llbit_d     = llbit_q;
        ll_addr_d   = ll_addr_q;
        cnt_d       = cnt_q;

        issue_cmd_c  = build_cmd(mem_we, mem_byte, addr, wdata);
        misaligned_c = !mem_byte && (addr[1:0] != 2'b00);
        sc_ok_c      = llbit_q && (ll_addr_q == addr[XLEN-1:2]);
        is_mem_op_c  = mem_read | mem_we;

        unique case (state_q)
            MAU_IDLE: begin
                if (req_valid && is_mem_op_c) begin
                    if (misaligned_c) begin
                        align_err_d = 1'b1;
                        rdata_d     = '0;
                        state_d     = MAU_DONE;
                    end else if (mem_sc && !sc_ok_c) begin
                        rdata_d = '0;
                        state_d = MAU_DONE;
                    end else begin
                        cmd_d         = issue_cmd_c;
                        ctx_d.ll      = mem_ll;
                        ctx_d.sc      = mem_sc;
                        ctx_d.byte_op = mem_byte;
                        ctx_d.sext    = mem_signextend;
                        ctx_d.ofs     = addr[1:0];
                        req_d         = 1'b1;
                        cnt_d         = '0;
                        state_d       = MAU_ACCESS;
                    end
                end
            end
            MAU_ACCESS: begin
                // An ack arriving in the expiry cycle still completes normally.
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = MAU_DONE;
                    if (cmd_q.we) begin
                        rdata_d = ctx_q.sc ? XLEN'(1) : '0;
                        if (ctx_q.sc || (ll_addr_q == cmd_q.addr[XLEN-1:2])) begin
                            llbit_d = 1'b0;
                        end
                    end else begin
                        rdata_d = aligned_c;
                        if (ctx_q.ll) begin
                            llbit_d   = 1'b1;
                            ll_addr_d = cmd_q.addr[XLEN-1:2];
                        end
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = MAU_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MAU_DONE: begin
                state_d = MAU_IDLE;
            end
            default: begin
                state_d = MAU_IDLE;
            end
        endcase

        // Exception/eret clear wins over a same-cycle LL completion.
        if (ll_clear) begin
            llbit_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit: directed and random loads/stores
// against a word-level memory/reservation model with a randomized ack responder.
module tb_mem_access_unit;

    localparam int TIMEOUT = 255;
    localparam int OP_LW = 0, OP_LB = 1, OP_LBU = 2, OP_SW = 3, OP_SB = 4, OP_LL = 5, OP_SC = 6;

    logic        clk, rst_n;
    logic        req_valid, mem_we, mem_read, mem_byte, mem_signextend, mem_sc, mem_ll;
    logic [31:0] addr, wdata;
    logic        ll_clear;
    logic        stall, align_err, bus_err;
    logic [31:0] rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

    mem_access_unit #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_we(mem_we), .mem_read(mem_read),
        .mem_byte(mem_byte), .mem_signextend(mem_signextend), .mem_sc(mem_sc), .mem_ll(mem_ll),
        .addr(addr), .wdata(wdata), .ll_clear(ll_clear), .stall(stall), .rdata(rdata),
        .align_err(align_err), .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; bit align; bit buserr; bit chk_rdata; } resp_t;
    typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } cmd_t;

    resp_t       resp_q[$];
    cmd_t        cmd_q[$];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] bus_mem [logic [29:0]];
    bit          ref_llbit;
    logic [29:0] ref_lladdr;
    int          ack_delay;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return ({2'b00, wa} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] bus_rd(input logic [29:0] wa);
        return bus_mem.exists(wa) ? bus_mem[wa] : init_word(wa);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        ref_mem[a[31:2]] = w;
        bus_mem[a[31:2]] = w;
    endtask

    // Memory responder: acks after ack_delay cycles, or never when negative.
    initial begin
        int d;
        logic [31:0] w;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (dmem_req) begin
                d = ack_delay;
                if (d < 0) begin
                    while (dmem_req) @(negedge clk);
                end else begin
                    repeat (d) @(negedge clk);
                    if (dmem_we) begin
                        w = bus_rd(dmem_addr[31:2]);
                        for (int i = 0; i < 4; i++)
                            if (dmem_be[i]) w[8*i +: 8] = dmem_wdata[8*i +: 8];
                        bus_mem[dmem_addr[31:2]] = w;
                    end
                    dmem_rdata = bus_rd(dmem_addr[31:2]);
                    dmem_ack   = 1'b1;
                    @(negedge clk);
                    dmem_ack   = 1'b0;
                    dmem_rdata = $urandom;
                end
            end
        end
    end

    // Monitor: bus command on each new request, response in each completion cycle.
    initial begin
        logic  prev_req;
        resp_t r;
        cmd_t  c;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (dmem_req && !prev_req) begin
                if (cmd_q.size() == 0) begin
                    check32("unexpected_dmem_req", 32'(dmem_req), 32'd0);
                end else begin
                    c = cmd_q.pop_front();
                    check32("dmem_we", 32'(dmem_we), 32'(c.we));
                    check32("dmem_be", 32'(dmem_be), 32'(c.be));
                    check32("dmem_addr", dmem_addr, c.addr);
                    check32("dmem_wdata", dmem_wdata, c.wdata);
                end
            end
            prev_req = dmem_req;
            if (rst_n && req_valid && !stall) begin
                if (resp_q.size() == 0) begin
                    check32("unexpected_done", 32'(stall), 32'd1);
                end else begin
                    r = resp_q.pop_front();
                    check32("align_err", 32'(align_err), 32'(r.align));
                    check32("bus_err", 32'(bus_err), 32'(r.buserr));
                    if (r.chk_rdata) check32("rdata", rdata, r.rdata);
                end
            end
        end
    end

    // Issues one instruction, predicts its outcome and waits for completion.
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] wd,
                          input int delay, input bit clr);
        bit          is_we, is_byte, is_sext, is_ll, is_sc;
        resp_t       r;
        cmd_t        c;
        int          exp_stall, n;
        logic [29:0] wa;
        logic [31:0] w;
        logic [7:0]  b;
        is_we   = (op == OP_SW) || (op == OP_SB) || (op == OP_SC);
        is_byte = (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
        is_sext = (op == OP_LB);
        is_ll   = (op == OP_LL);
        is_sc   = (op == OP_SC);
        wa      = a[31:2];
        r.rdata = 32'h0; r.align = 1'b0; r.buserr = 1'b0; r.chk_rdata = 1'b1;
        if (!is_byte && a[1:0] != 2'b00) begin
            r.align   = 1'b1;
            exp_stall = 1;
        end else if (is_sc && !(ref_llbit && ref_lladdr == wa)) begin
            exp_stall = 1;
        end else begin
            c.we   = is_we;
            c.addr = {a[31:2], 2'b00};
            c.be   = is_byte ? 4'(1 << a[1:0]) : 4'hF;
            c.wdata = is_byte ? {4{wd[7:0]}} : wd;
            cmd_q.push_back(c);
            if (delay < 0) begin
                r.buserr  = 1'b1;
                exp_stall = 1 + TIMEOUT;
            end else begin
                exp_stall = delay + 2;
                w = ref_rd(wa);
                if (is_we) begin
                    if (is_byte) w[8*a[1:0] +: 8] = wd[7:0];
                    else w = wd;
                    ref_mem[wa] = w;
                    if (ref_llbit && ref_lladdr == wa) ref_llbit = 1'b0;
                    if (is_sc) r.rdata = 32'd1;
                    else r.chk_rdata = 1'b0;
                end else begin
                    if (is_byte) begin
                        b = w[8*a[1:0] +: 8];
                        r.rdata = is_sext ? {{24{b[7]}}, b} : {24'h0, b};
                    end else begin
                        r.rdata = w;
                    end
                    if (is_ll) begin
                        ref_llbit  = 1'b1;
                        ref_lladdr = wa;
                    end
                end
            end
        end
        if (clr) ref_llbit = 1'b0;
        resp_q.push_back(r);

        ack_delay      = delay;
        mem_we         = is_we;
        mem_read       = !is_we;
        mem_byte       = is_byte;
        mem_signextend = is_sext;
        mem_sc         = is_sc;
        mem_ll         = is_ll;
        addr           = a;
        wdata          = wd;
        ll_clear       = clr;
        req_valid      = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 600) begin
                checks++;
                errors++;
                $display("FAIL stall_bound: stall still high after %0d cycles, op %0d addr %h", n, op, a);
                finish_run();
            end
        end
        check32("stall_cycles", 32'(n), 32'(exp_stall));
        @(posedge clk);
        #1;
        req_valid = 1'b0; mem_we = 1'b0; mem_read = 1'b0; mem_byte = 1'b0;
        mem_signextend = 1'b0; mem_sc = 1'b0; mem_ll = 1'b0; ll_clear = 1'b0;
        @(negedge clk);
        check32("err_pulse_width", 32'({align_err, bus_err}), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        ll_clear = 1'b1;
        @(posedge clk);
        #1;
        ll_clear  = 1'b0;
        ref_llbit = 1'b0;
    endtask

    initial begin
        cmd_t        c;
        int          op, ofs;
        logic [31:0] a, last_ll;
        rst_n = 1'b0; req_valid = 1'b0; mem_we = 1'b0; mem_read = 1'b0; mem_byte = 1'b0;
        mem_signextend = 1'b0; mem_sc = 1'b0; mem_ll = 1'b0; addr = 32'h0; wdata = 32'h0;
        ll_clear = 1'b0; ack_delay = 0; ref_llbit = 1'b0; ref_lladdr = 30'h0;
        last_ll = 32'h400;

        repeat (3) @(posedge clk);
        #1;
        check32("reset_dmem_req", 32'(dmem_req), 32'd0);
        check32("reset_dmem_be", 32'(dmem_be), 32'd0);
        check32("reset_dmem_addr", dmem_addr, 32'd0);
        check32("reset_rdata", rdata, 32'd0);
        check32("reset_errs", 32'({align_err, bus_err}), 32'd0);
        rst_n = 1'b1;

        preload(32'h100, 32'hDEADBEEF);
        run_op(OP_LW, 32'h100, 32'h0, 2, 1'b0);
        preload(32'h100, 32'h80112233);
        run_op(OP_LB, 32'h103, 32'h0, 1, 1'b0);
        run_op(OP_LBU, 32'h103, 32'h0, 0, 1'b0);
        run_op(OP_SB, 32'h101, 32'h000000AB, 1, 1'b0);
        run_op(OP_LW, 32'h100, 32'h0, 0, 1'b0);
        run_op(OP_LL, 32'h200, 32'h0, 0, 1'b0);
        run_op(OP_SC, 32'h200, 32'h12345678, 1, 1'b0);
        run_op(OP_SC, 32'h200, 32'h87654321, 0, 1'b0);
        run_op(OP_LL, 32'h200, 32'h0, 1, 1'b0);
        run_op(OP_SW, 32'h200, 32'hCAFEF00D, 0, 1'b0);
        run_op(OP_SC, 32'h200, 32'h11111111, 0, 1'b0);
        run_op(OP_LL, 32'h200, 32'h0, 0, 1'b0);
        pulse_clr();
        run_op(OP_SC, 32'h200, 32'h22222222, 0, 1'b0);
        run_op(OP_LL, 32'h204, 32'h0, 0, 1'b1);
        run_op(OP_SC, 32'h204, 32'h33333333, 0, 1'b0);
        run_op(OP_SW, 32'h102, 32'h44444444, 0, 1'b0);
        run_op(OP_LL, 32'h203, 32'h0, 0, 1'b0);
        run_op(OP_LW, 32'h300, 32'h0, -1, 1'b0);
        run_op(OP_LW, 32'h300, 32'h0, 0, 1'b0);

        // Reset during ACCESS; the responder's late ack must be ignored.
        run_op(OP_LL, 32'h180, 32'h0, 0, 1'b0);
        ack_delay = 10;
        c.we = 1'b0; c.be = 4'hF; c.addr = 32'h140; c.wdata = 32'h0;
        cmd_q.push_back(c);
        mem_read = 1'b1; addr = 32'h140; req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0;
        #1;
        check32("rst_access_req", 32'({dmem_req, dmem_we}), 32'd0);
        check32("rst_access_be", 32'(dmem_be), 32'd0);
        check32("rst_access_addr", dmem_addr, 32'd0);
        check32("rst_access_rdata", rdata, 32'd0);
        ref_llbit = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check32("late_ack_req", 32'(dmem_req), 32'd0);
        check32("late_ack_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        run_op(OP_SC, 32'h180, 32'h55555555, 0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            op  = int'($urandom_range(0, 6));
            ofs = int'($urandom_range(0, 3));
            if (!(op == OP_LB || op == OP_LBU || op == OP_SB) && $urandom_range(0, 7) != 0) ofs = 0;
            a = 32'h400 + 32'($urandom_range(0, 7)) * 4 + 32'(ofs);
            if (op == OP_SC && $urandom_range(0, 1) == 1) a = last_ll;
            if (op == OP_LL && ofs == 0) last_ll = a;
            run_op(op, a, $urandom, int'($urandom_range(0, 4)), 1'b0);
            if ($urandom_range(0, 11) == 0) pulse_clr();
        end

        repeat (3) @(posedge clk);
        check32("resp_q_drained", 32'(resp_q.size()), 32'd0);
        check32("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        finish_run();
    end

endmodule
